// File: rtl/regfile_bist_pkg.sv
// Shared types and constants for the register-file BIST controller.
// REGFILE_BIST_INVERT_PASS_EN adds the complemented-pattern states to the state enum.
package regfile_bist_pkg;

  localparam logic [15:0] PATTERN_HI = 16'hA5C3;
  localparam int          NUM_REGS   = 32;
  localparam logic [5:0]  ERR_MAX    = 6'd63;
  localparam logic [4:0]  LAST_IDX   = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
`ifdef REGFILE_BIST_INVERT_PASS_EN
    INV_WRITE,
    INV_READ,
`endif
    DONE
  } state_t;

  function automatic logic [31:0] pattern(input logic [4:0] i, input logic inv);
    logic [31:0] p;
    p = {PATTERN_HI, 11'b0, i};
    return inv ? ~p : p;
  endfunction

  // r0 is hardwired to zero, so it always reads back 0 whatever was written.
  function automatic logic [31:0] expected(input logic [4:0] i, input logic inv);
    return (i == 5'd0) ? 32'd0 : pattern(i, inv);
  endfunction

endpackage

// File: rtl/regfile_bist.sv
// March-style BIST for a 32x32 register file: write pattern, read back and compare.
// Define REGFILE_BIST_INVERT_PASS_EN to add a second pass with the complemented pattern.
module regfile_bist
  import regfile_bist_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        test,
  output logic        t_ctrl_writeEnable,
  output logic [4:0]  t_ctrl_writeReg,
  output logic [4:0]  t_ctrl_readRegA,
  output logic [4:0]  t_ctrl_readRegB,
  output logic [31:0] t_data_writeReg,
  input  logic [31:0] t_data_readRegA,
  input  logic [31:0] t_data_readRegB,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic [4:0]  first_fail_reg,
  output logic        fail_valid
);

  state_t      state, state_n;
  logic [4:0]  idx, idx_n;
  logic        clear;
  logic        cmp_en;
  logic        inv;
  logic        mismatch;
  logic [31:0] exp_data;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_n            = state;
    idx_n              = idx;
    clear              = 1'b0;
    cmp_en             = 1'b0;
    inv                = 1'b0;
    test               = 1'b0;
    t_ctrl_writeEnable = 1'b0;
    t_ctrl_writeReg    = '0;
    t_ctrl_readRegA    = '0;
    t_ctrl_readRegB    = '0;
    t_data_writeReg    = '0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WRITE;
          idx_n   = '0;
          clear   = 1'b1;
        end
      end
`ifdef REGFILE_BIST_INVERT_PASS_EN
      WRITE, INV_WRITE: begin
        inv = (state == INV_WRITE);
`else
      WRITE: begin
`endif
        test               = 1'b1;
        t_ctrl_writeEnable = 1'b1;
        t_ctrl_writeReg    = idx;
        t_data_writeReg    = pattern(idx, inv);
        idx_n              = idx + 5'd1;
        if (idx == LAST_IDX) begin
`ifdef REGFILE_BIST_INVERT_PASS_EN
          state_n = inv ? INV_READ : READ;
`else
          state_n = READ;
`endif
        end
      end
`ifdef REGFILE_BIST_INVERT_PASS_EN
      READ, INV_READ: begin
        inv = (state == INV_READ);
`else
      READ: begin
`endif
        test            = 1'b1;
        t_ctrl_readRegA = idx;
        t_ctrl_readRegB = idx;
        cmp_en          = 1'b1;
        idx_n           = idx + 5'd1;
        if (idx == LAST_IDX) begin
`ifdef REGFILE_BIST_INVERT_PASS_EN
          state_n = inv ? DONE : INV_WRITE;
`else
          state_n = DONE;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  assign exp_data = expected(idx, inv);
  // A register fails once even if both ports disagree.
  assign mismatch = cmp_en &&
                    ((t_data_readRegA != exp_data) || (t_data_readRegB != exp_data));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      err_count      <= '0;
      first_fail_reg <= '0;
      fail_valid     <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (clear) begin
        err_count      <= '0;
        first_fail_reg <= '0;
        fail_valid     <= 1'b0;
      end else if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 6'd1;
        if (!fail_valid) begin
          first_fail_reg <= idx;
          fail_valid     <= 1'b1;
        end
      end
    end
  end

  assign done = (state == DONE);
  assign pass = done && (err_count == 6'd0);

endmodule

// File: tb/tb_regfile_bist.sv
// Scoreboard bench for regfile_bist with a fault-injectable register-file model.
// Expected results are adjusted when REGFILE_BIST_INVERT_PASS_EN is defined.
module tb_regfile_bist;

`ifdef REGFILE_BIST_INVERT_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        test;
  logic        t_ctrl_writeEnable;
  logic [4:0]  t_ctrl_writeReg;
  logic [4:0]  t_ctrl_readRegA;
  logic [4:0]  t_ctrl_readRegB;
  logic [31:0] t_data_writeReg;
  logic [31:0] t_data_readRegA;
  logic [31:0] t_data_readRegB;
  logic        done;
  logic        pass;
  logic [5:0]  err_count;
  logic [4:0]  first_fail_reg;
  logic        fail_valid;

  regfile_bist dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .test               (test),
    .t_ctrl_writeEnable (t_ctrl_writeEnable),
    .t_ctrl_writeReg    (t_ctrl_writeReg),
    .t_ctrl_readRegA    (t_ctrl_readRegA),
    .t_ctrl_readRegB    (t_ctrl_readRegB),
    .t_data_writeReg    (t_data_writeReg),
    .t_data_readRegA    (t_data_readRegA),
    .t_data_readRegB    (t_data_readRegB),
    .done               (done),
    .pass               (pass),
    .err_count          (err_count),
    .first_fail_reg     (first_fail_reg),
    .fail_valid         (fail_valid)
  );

  always #5 clock = ~clock;

  // Register file model; faults act on the read path.
  logic [31:0] mem [32];
  logic [31:0] stuck_zero;
  logic [31:0] stuck1_b31;
  logic [31:0] corrupt_b;

  always @(posedge clock)
    if (test && t_ctrl_writeEnable && t_ctrl_writeReg != 5'd0)
      mem[t_ctrl_writeReg] <= t_data_writeReg;

  always_comb begin
    t_data_readRegA = (t_ctrl_readRegA == 5'd0) ? 32'd0 : mem[t_ctrl_readRegA];
    if (stuck_zero[t_ctrl_readRegA]) t_data_readRegA = 32'd0;
    if (stuck1_b31[t_ctrl_readRegA]) t_data_readRegA[31] = 1'b1;
    t_data_readRegB = (t_ctrl_readRegB == 5'd0) ? 32'd0 : mem[t_ctrl_readRegB];
    if (stuck_zero[t_ctrl_readRegB]) t_data_readRegB = 32'd0;
    if (stuck1_b31[t_ctrl_readRegB]) t_data_readRegB[31] = 1'b1;
    if (corrupt_b[t_ctrl_readRegB]) t_data_readRegB = t_data_readRegB ^ 32'd1;
  end

  typedef struct {
    int         edge_no;
    logic [5:0] err;
    logic [4:0] ffr;
    logic       fv;
    logic       pass;
    int         writes;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   wcount   = 0;
  logic done_q   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: checks every write beat and pops a scoreboard entry on each done rise.
  always @(negedge clock) begin
    int          slot;
    logic [31:0] p;
    exp_t        e;
    if (test && t_ctrl_writeEnable) begin
      slot = wcount % 32;
      p = {16'hA5C3, 11'b0, 5'(slot)};
      if (wcount >= 32) p = ~p;
      check("write_reg", 32'(t_ctrl_writeReg), 32'(slot));
      check("write_data", t_data_writeReg, p);
      wcount++;
    end
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_edge", 32'(cyc), 32'(e.edge_no));
        check("err_count", 32'(err_count), 32'(e.err));
        check("first_fail_reg", 32'(first_fail_reg), 32'(e.ffr));
        check("fail_valid", 32'(fail_valid), 32'(e.fv));
        check("pass", 32'(pass), 32'(e.pass));
        check("write_beats", 32'(wcount), 32'(e.writes));
        check("test_in_done", 32'(test), 32'd0);
      end
    end
    done_q = done;
  end

  task automatic check_idle(input string tag);
    check({tag, "_test"}, 32'(test), 32'd0);
    check({tag, "_ctrl"}, {16'd0, 1'b0, t_ctrl_writeEnable, t_ctrl_writeReg,
                           t_ctrl_readRegA, t_ctrl_readRegB}, 32'd0);
    check({tag, "_wdata"}, t_data_writeReg, 32'd0);
    check({tag, "_status"}, {20'd0, done, pass, err_count, fail_valid, first_fail_reg[2:0]}, 32'd0);
    check({tag, "_ffr"}, 32'(first_fail_reg), 32'd0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [5:0] err, input logic [4:0] ffr, input int held);
    exp_t e;
    @(negedge clock);
    wcount    = 0;
    e.edge_no = cyc + 1 + 64 * PASSES;
    e.err     = err;
    e.ffr     = ffr;
    e.fv      = (err != 6'd0);
    e.pass    = (err == 6'd0);
    e.writes  = 32 * PASSES;
    sb.push_back(e);
    start = 1'b1;
    repeat (held) @(negedge clock);
    start = 1'b0;
    drain(200 * PASSES);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    stuck_zero = '0;
    stuck1_b31 = '0;
    corrupt_b  = '0;

    repeat (3) @(negedge clock);
    check_idle("reset");
    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(negedge clock);
    check_idle("reset_vs_start");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check_idle("idle");

    run(6'd0, 5'd0, 1);                         // fault-free
    stuck_zero[5] = 1'b1;
    run(6'(PASSES), 5'd5, 1);                   // r5 reads 0
    stuck_zero = '0;
    corrupt_b[7] = 1'b1;
    corrupt_b[9] = 1'b1;
    run(6'(2 * PASSES), 5'd7, 1);               // port B only on r7, r9
    corrupt_b = '0;
    // r3 bit 31 forced high: matches A5C3_0003, breaks only 5A3C_FFFC.
    stuck1_b31[3] = 1'b1;
    run(6'(PASSES - 1), (PASSES == 2) ? 5'd3 : 5'd0, 1);
    stuck1_b31 = '0;

    // Reset in the middle of READ at idx 12.
    @(negedge clock);
    wcount = 0;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!(test && !t_ctrl_writeEnable && t_ctrl_readRegA == 5'd12) && n < 200) begin
        @(negedge clock);
        n++;
      end
      check("reach_read_12", 32'(t_ctrl_readRegA), 32'd12);
    end
    reset = 1'b1;
    @(negedge clock);
    check_idle("mid_run_reset");
    reset = 1'b0;
    run(6'd0, 5'd0, 1);

    // All registers read 0; start held for three cycles.
    stuck_zero = '1;
    run(6'(31 * PASSES), 5'd1, 3);
    stuck_zero = '0;
    check("done_held", 32'(done), 32'd1);
    run(6'd0, 5'd0, 1);                         // restart from DONE clears results

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
